score_ctrl: RTL and testbench

- Sequential score keeper and display controller for the score renderer.
- Counts surviving distance in frames while the game runs, saturating at a maximum.
- Converts binary scores to packed BCD digits with one shared multi-cycle shift-add-3 converter, arbitrated between the live score and the high score.
- Presents stable, glitch-free digit registers to the renderer, which no longer divides per pixel.

---
 rtl/score_pkg.sv | 17 +
 rtl/bin2bcd_seq.sv | 78 +++++++
 rtl/score_ctrl.sv | 147 ++++++++++++++
 tb/tb_score_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types and default parameters for the score keeper.
package score_pkg;

    // Converter sequence states.
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    // Which digit register a conversion result goes to.
    typedef enum logic {TGT_SCORE, TGT_HI} conv_target_t;

    localparam int BCD_W = 4;

    localparam int DEF_DIGITS      = 2;
    localparam int DEF_SCORE_W     = 8;
    localparam int DEF_UNIT_FRAMES = 30;
    localparam int DEF_MAX_SCORE   = 99;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle shift-add-3 binary to packed BCD converter.
// start in IDLE -> LOAD (snapshot bin) -> SHIFT x SCORE_W -> DONE (done=1) -> IDLE.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int DIGITS  = DEF_DIGITS,
    parameter int SCORE_W = DEF_SCORE_W
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      start,
    input  logic [SCORE_W-1:0]        bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd
);

    localparam int BCD_F = BCD_W * DIGITS;
    localparam int SR_W  = BCD_F + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    conv_state_t       state, state_nxt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: SHIFT leaves once the last bit has been shifted in.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[SCORE_W + BCD_W*d +: BCD_W] >= 4'd5)
                sr_adj[SCORE_W + BCD_W*d +: BCD_W] = sr[SCORE_W + BCD_W*d +: BCD_W] + 4'd3;
        end
    end

    // Shift register and bit counter datapath.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    sr  <= {{BCD_F{1'b0}}, bin};
                    cnt <= CNT_W'(SCORE_W);
                end
                SHIFT: begin
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = sr[SR_W-1 -: BCD_F];

endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: frame-based score keeper with shared BCD conversion for the renderer.
// Optional macro SCORE_HISCORE_EN adds high-score tracking and converter arbitration;
// without it hi_digits is 0 and the converter serves the live score only.
module score_ctrl
    import score_pkg::*;
#(
    parameter int DIGITS      = DEF_DIGITS,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int UNIT_FRAMES = DEF_UNIT_FRAMES,
    parameter int MAX_SCORE   = DEF_MAX_SCORE
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_clk,
    input  logic                     playing,
    input  logic                     restart,
    output logic [SCORE_W-1:0]       score_bin,
    output logic [BCD_W*DIGITS-1:0]  score_digits,
    output logic [BCD_W*DIGITS-1:0]  hi_digits,
    output logic                     score_valid,
    output logic                     conv_busy
);

    localparam int FC_W = $clog2(UNIT_FRAMES + 1);

    logic                     frame_prev;
    logic                     frame_tick;
    logic [FC_W-1:0]          frame_cnt;
    logic                     score_inc;
    logic                     score_pend;
    logic                     start;
    logic                     grant_score;
    conv_target_t             target;
    logic [SCORE_W-1:0]       conv_bin;
    logic                     conv_done;
    logic [BCD_W*DIGITS-1:0]  conv_bcd;

    assign frame_tick = frame_clk & ~frame_prev;
    assign score_inc  = frame_tick & playing & ~restart &
                        (frame_cnt == FC_W'(UNIT_FRAMES - 1));

    // Frame edge detect, prescaler and saturating score; restart wins over a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_prev <= 1'b0;
            frame_cnt  <= '0;
            score_bin  <= '0;
        end else begin
            frame_prev <= frame_clk;
            if (restart) begin
                frame_cnt <= '0;
                score_bin <= '0;
            end else if (frame_tick && playing) begin
                if (frame_cnt == FC_W'(UNIT_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    if (score_bin != SCORE_W'(MAX_SCORE))
                        score_bin <= score_bin + SCORE_W'(1);
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
            end
        end
    end

    // Score conversion request; a new request beats a same-cycle grant so none is lost.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                    score_pend <= 1'b0;
        else if (restart || score_inc)   score_pend <= 1'b1;
        else if (grant_score)            score_pend <= 1'b0;
    end

`ifdef SCORE_HISCORE_EN
    logic               playing_prev;
    logic               game_over;
    logic [SCORE_W-1:0] hi_bin;
    logic               hi_pend;
    logic               hi_set;
    logic               grant_hi;

    assign game_over   = playing_prev & ~playing;
    assign hi_set      = game_over & (score_bin > hi_bin);
    assign start       = ~conv_busy & (score_pend | hi_pend);
    assign grant_score = start & score_pend;
    assign grant_hi    = start & ~score_pend & hi_pend;
    assign conv_bin    = (target == TGT_HI) ? hi_bin : score_bin;

    // High score capture on game over; strictly greater scores only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            playing_prev <= 1'b0;
            hi_bin       <= '0;
            hi_pend      <= 1'b0;
        end else begin
            playing_prev <= playing;
            if (hi_set)        hi_bin  <= score_bin;
            if (hi_set)        hi_pend <= 1'b1;
            else if (grant_hi) hi_pend <= 1'b0;
        end
    end

    // Latch the arbitration winner so DONE knows where the result goes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)   target <= TGT_SCORE;
        else if (start) target <= grant_score ? TGT_SCORE : TGT_HI;
    end

    // High-score digit register, written only at the end of a high-score pass.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                            hi_digits <= '0;
        else if (conv_done && target == TGT_HI)  hi_digits <= conv_bcd;
    end
`else
    assign start       = ~conv_busy & score_pend;
    assign grant_score = start;
    assign target      = TGT_SCORE;
    assign conv_bin    = score_bin;
    assign hi_digits   = '0;
`endif

    // Score digit register and its update pulse, aligned with the new digits.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_digits <= '0;
            score_valid  <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            if (conv_done && target == TGT_SCORE) begin
                score_digits <= conv_bcd;
                score_valid  <= 1'b1;
            end
        end
    end

    bin2bcd_seq #(
        .DIGITS  (DIGITS),
        .SCORE_W (SCORE_W)
    ) u_conv (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .bin     (conv_bin),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed and randomized checks of score_ctrl against a frame-level model.
// Hi-score scenarios are exercised when SCORE_HISCORE_EN is defined.
module tb_score_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       playing = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] score_bin;
    logic [7:0] score_digits;
    logic [7:0] hi_digits;
    logic       score_valid;
    logic       conv_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    score_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .playing      (playing),
        .restart      (restart),
        .score_bin    (score_bin),
        .score_digits (score_digits),
        .hi_digits    (hi_digits),
        .score_valid  (score_valid),
        .conv_busy    (conv_busy)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int from_bcd(input int b);
        return ((b >> 4) & 15) * 10 + (b & 15);
    endfunction

    // Frame-level model: 30 frames per point, saturate at 99, restart clears,
    // high score taken on game over when strictly greater.
    int m_score = 0, m_cnt = 0, m_hi = 0;
    bit m_fprev = 0, m_pprev = 0, m_tick, m_fall;
    int m_old;
    int hist[32];
    int hp = 0;

    always @(posedge Clk) begin
        if (!Reset_n) begin
            m_score = 0; m_cnt = 0; m_hi = 0; m_fprev = 0; m_pprev = 0;
        end else begin
            m_tick = frame_clk && !m_fprev;
            m_fall = m_pprev && !playing;
            m_old  = m_score;
            if (restart) begin
                m_score = 0; m_cnt = 0;
            end else if (m_tick && playing) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 30) begin
                    m_cnt = 0;
                    if (m_score < 99) m_score = m_score + 1;
                end
            end
            if (m_fall && m_old > m_hi) m_hi = m_old;
            m_fprev = frame_clk;
            m_pprev = playing;
        end
        hist[hp] = m_score;
        hp = (hp + 1) % 32;
    end

    // Per-cycle compare: live score exact; every published score is a recent true score.
    always @(negedge Clk) begin
        if (Reset_n) begin
            check("score_bin", score_bin, m_score);
            if (score_valid) begin
                bit found;
                found = 0;
                n_valid++;
                for (int i = 0; i < 32; i++)
                    if (hist[i] == from_bcd(score_digits) && to_bcd(hist[i]) == score_digits)
                        found = 1;
                check("valid_digits_recent", found, 1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    // Let any chained conversions drain, then compare digit registers to the model.
    task automatic settle();
        cyc(40);
        check("settle_busy", conv_busy, 0);
        check("settle_score_digits", score_digits, to_bcd(m_score));
`ifdef SCORE_HISCORE_EN
        check("settle_hi_digits", hi_digits, to_bcd(m_hi));
`else
        check("settle_hi_digits", hi_digits, 0);
`endif
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; playing = 1'b0; restart = 1'b0; frame_clk = 1'b0;
        cyc(2);
        check("rst_score_bin", score_bin, 0);
        check("rst_score_digits", score_digits, 0);
        check("rst_hi_digits", hi_digits, 0);
        check("rst_valid", score_valid, 0);
        check("rst_busy", conv_busy, 0);
        Reset_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        int lat, v0, busy_n;
        @(negedge Clk);
        do_reset();

        // First point after 30 frames, digits 11 cycles after score_bin moves.
        playing = 1'b1;
        v0 = n_valid;
        frames(29);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        check("first_point_bin", score_bin, 1);
        lat = 0;
        while (!score_valid && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        check("first_point_latency", lat, 11);
        check("first_point_digits", score_digits, 8'h01);
        settle();
        check("first_point_one_pulse", n_valid - v0, 1);

        // 1200 frames -> 40; 2970 frames -> saturate at 99 and stay.
        frames(1170);
        settle();
        check("frames_1200", score_digits, 8'h40);
        frames(1770);
        settle();
        check("frames_2970", score_digits, 8'h99);
        frames(90);
        settle();
        check("saturated_bin", score_bin, 99);
        check("saturated_digits", score_digits, 8'h99);

        // Restart coincident with a scoring tick clears the score.
        do_reset();
        playing = 1'b1;
        frames(119);
        frame_clk = 1'b1;
        restart = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        restart = 1'b0;
        check("restart_wins_bin", score_bin, 0);
        @(negedge Clk);
        settle();
        check("restart_wins_digits", score_digits, 8'h00);

`ifdef SCORE_HISCORE_EN
        // High score 57, then a lower run leaves it unchanged.
        do_reset();
        playing = 1'b1;
        frames(1710);
        playing = 1'b0;
        settle();
        check("hi_57", hi_digits, 8'h57);
        restart = 1'b1; playing = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        frames(360);
        playing = 1'b0;
        settle();
        check("hi_kept_57", hi_digits, 8'h57);
        check("score_12", score_digits, 8'h12);

        // Both requests at once: score pass first, then the high-score pass.
        restart = 1'b1; playing = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        frames(1800);
        playing = 1'b0; restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        lat = 0; busy_n = 0;
        while (!score_valid && lat < 40) begin
            if (conv_busy) busy_n++;
            @(negedge Clk);
            lat++;
        end
        check("both_score_first", score_digits, 8'h00);
        check("both_hi_not_yet", hi_digits, 8'h57);
        repeat (30) begin
            if (conv_busy) busy_n++;
            @(negedge Clk);
        end
        // Two full passes of LOAD + 8 SHIFT + DONE.
        check("both_busy_cycles", busy_n, 20);
        settle();
        check("both_hi_60", hi_digits, 8'h60);
`endif

        // Reset during SHIFT aborts with no output update and no late pulse.
        do_reset();
        playing = 1'b1;
        frames(30);
        cyc(3);
        check("midshift_busy", conv_busy, 1);
        Reset_n = 1'b0;
        cyc(1);
        check("midshift_rst_digits", score_digits, 0);
        check("midshift_rst_busy", conv_busy, 0);
        playing = 1'b0;
        Reset_n = 1'b1;
        v0 = n_valid;
        cyc(20);
        check("midshift_no_pulse", n_valid - v0, 0);
        check("midshift_digits", score_digits, 0);

        // Randomized play: frames with random gaps, restarts, playing toggles.
        do_reset();
        playing = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 75) begin
                frame_clk = 1'b1;
                @(negedge Clk);
                frame_clk = 1'b0;
                cyc($urandom_range(1, 3));
            end else if (r < 77) begin
                restart = 1'b1;
                @(negedge Clk);
                restart = 1'b0;
            end else if (r < 81) begin
                playing = ~playing;
                @(negedge Clk);
            end else begin
                @(negedge Clk);
            end
            if (i % 1000 == 999) settle();
        end
        playing = 1'b0;
        @(negedge Clk);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
